// File: rtl/pipeline_controller_if.sv
// Hazard/control bus between the pipeline datapath and its controller.
// Datapath (master) supplies decode/execute fields; controller (slave) returns stall/flush and status.
// Purely combinational wiring; no storage, no backpressure of its own.
interface pipeline_controller_if;
    logic [31:0] instrD;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        memReadE;
    logic [4:0]  rtE;
    logic        branchE;
    logic        zeroE;
    logic        isJE;
    logic        isJALE;
    logic        isJRE;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic [2:0]  state;
    logic        done;
    logic [31:0] cycle_count;

    modport master (
        output instrD, rsD, rtD, memReadE, rtE,
        output branchE, zeroE, isJE, isJALE, isJRE,
        input  stallF, stallD, flushD, flushE, flushM,
        input  state, done, cycle_count
    );

    modport slave (
        input  instrD, rsD, rtD, memReadE, rtE,
        input  branchE, zeroE, isJE, isJALE, isJRE,
        output stallF, stallD, flushD, flushE, flushM,
        output state, done, cycle_count
    );
endinterface

// File: rtl/pipeline_controller.sv
// Five-stage pipeline hazard controller: load-use stalls, redirect squash, halt drain, cycle counter.
// Stall/flush outputs are combinational from the registered state and current inputs (0 cycles).
// Backpressure is the stall/flush outputs themselves; the controller never waits on the datapath.
module pipeline_controller #(
    parameter int          FLUSH_CYCLES = 3,
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [31:0] HALT_WORD    = 32'hFFFFFFFF
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_controller_if.slave  pc
);
    // A parameter of 0 is treated as 1 so every squash/drain lasts at least one cycle.
    localparam int FL   = (FLUSH_CYCLES < 1) ? 1 : FLUSH_CYCLES;
    localparam int DL   = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int MAXC = (FL > DL) ? FL : DL;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] FL_LOAD = CW'(FL);
    localparam logic [CW-1:0] DL_LOAD = CW'(DL);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] ZERO    = '0;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_STALL = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [31:0]     cycle_count_q, cycle_count_d;
    logic            done_q, done_d;

    logic            redirect;
    logic            loaduse;
    logic            halt;
    logic            stall_f;
    logic            stall_d;
    logic            flush_d;
    logic            flush_e;
    logic            flush_m;

    // Hazard terms decoded from the current decode/execute fields.
    always_comb begin
        redirect = (pc.branchE & pc.zeroE) | pc.isJE | pc.isJALE | pc.isJRE;
        loaduse  = pc.memReadE & (pc.rtE != 5'd0) &
                   ((pc.rtE == pc.rsD) | (pc.rtE == pc.rtD));
        halt     = (pc.instrD == HALT_WORD);
    end

    // Next-state, counters and stall/flush outputs; in RUN redirect beats loaduse beats halt.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_count_d = cycle_count_q;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_m       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    flush_d     = 1'b1;
                    flush_e     = 1'b1;
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FL_LOAD;
                end else if (loaduse) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    state_d = ST_STALL;
                end else if (halt) begin
                    stall_f     = 1'b1;
                    flush_d     = 1'b1;
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DL_LOAD;
                end
            end
            // The bubble now in EX cannot hold a control transfer, so just resume.
            ST_STALL: begin
                state_d = ST_RUN;
            end
            // Wrong-path instructions are squashed at EX/MEM; their hazards are ignored.
            ST_FLUSH: begin
                flush_m = 1'b1;
                if (flush_cnt_q <= ONE) begin
                    flush_cnt_d = ZERO;
                    state_d     = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - ONE;
                end
            end
            // Fetch is frozen and decode is bubbled while older instructions retire.
            ST_DRAIN: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                if (drain_cnt_q <= ONE) begin
                    drain_cnt_d = ZERO;
                    state_d     = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - ONE;
                end
            end
            ST_DONE: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (state_q != ST_DONE) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
        done_d = (state_d == ST_DONE);
    end

    // State, counters and status flops; reset overrides everything including DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            flush_cnt_q   <= ZERO;
            drain_cnt_q   <= ZERO;
            cycle_count_q <= 32'd0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
        end
    end

    assign pc.stallF      = stall_f;
    assign pc.stallD      = stall_d;
    assign pc.flushD      = flush_d;
    assign pc.flushE      = flush_e;
    assign pc.flushM      = flush_m;
    assign pc.state       = state_q;
    assign pc.done        = done_q;
    assign pc.cycle_count = cycle_count_q;
endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 Parameter FLUSH_CYCLES, default 3: EX->MEM squash cycles after a redirect.
REQ-002 Parameter DRAIN_CYCLES, default 3: cycles between halt detection and done.
REQ-003 Parameter HALT_WORD, default 32'hFFFFFFFF: instruction encoding that ends the program.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 instrD  in  32  instruction held in the IF/ID register.
REQ-007 rsD, rtD  in  5 each  source register fields of the decode-stage instruction.
REQ-008 memReadE, rtE  in  1, 5  load flag and load destination in the ID/EX register.
REQ-009 branchE, zeroE, isJE, isJALE, isJRE  in  1 each  execute-stage control-transfer flags.
REQ-010 stallF, stallD  out  1 each  hold PC and the IF/ID register.
REQ-011 flushD, flushE, flushM  out  1 each  zero the IF/ID, ID/EX and EX/MEM register contents on the next edge.
REQ-012 state  out  3  encoding: RUN=0, STALL=1, FLUSH=2, DRAIN=3, DONE=4.
REQ-013 done  out  1  program complete; cycle_count  out  32  cycles elapsed since reset.

Function
REQ-014 The FSM SHALL be registered; stallF, stallD and flush* SHALL be combinational functions of the current state and inputs.
REQ-015 Term redirect = (branchE & zeroE) | isJE | isJALE | isJRE.
REQ-016 Term loaduse = memReadE & (rtE != 0) & ((rtE == rsD) | (rtE == rtD)).
REQ-017 Term halt = (instrD == HALT_WORD).
REQ-018 Precedence in RUN: redirect > loaduse > halt; only the highest-priority condition acts.
REQ-019 RUN, redirect: flushD=1, flushE=1; next state FLUSH, squash counter loaded with FLUSH_CYCLES.
REQ-020 RUN, loaduse only: stallF=1, stallD=1, flushE=1 in that cycle; next state STALL.
REQ-021 STALL: all stall/flush outputs 0; next state RUN unconditionally.
REQ-022 STALL: a redirect input is ignored, since the bubble in EX cannot carry one.
REQ-023 FLUSH: flushM=1 every cycle; counter decrements each cycle; FSM returns to RUN on the edge where the counter goes 1->0.
REQ-024 FLUSH: FLUSH has exactly FLUSH_CYCLES cycles of flushM=1.
REQ-025 FLUSH: redirect, loaduse and halt are all ignored, because they belong to the wrong path.
REQ-026 RUN, halt only: stallF=1, flushD=1; next state DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-027 DRAIN: stallF=1 and flushD=1 each cycle; counter decrements.
REQ-028 DRAIN: the transition to DONE occurs on the edge where the counter goes 1->0.
REQ-029 DRAIN: redirect and loaduse are ignored.
REQ-030 DONE: stallF=1 and stallD=1; flush outputs 0.
REQ-031 DONE: done=1.
REQ-032 DONE: the FSM remains in DONE until reset.
REQ-033 cycle_count SHALL increment by 1 on every edge in which the state is not DONE.
REQ-034 cycle_count SHALL freeze on entry to DONE and wrap modulo 2^32.
REQ-035 Counters SHALL be wide enough for the parameter values; a parameter value of 0 SHALL behave as 1.

Reset
REQ-036 While reset=1 at an edge: state<=RUN, both counters<=0, cycle_count<=0, done<=0.
REQ-037 Reset SHALL take precedence over every other event, including in FLUSH, DRAIN and DONE.
REQ-038 While state=RUN after reset with no hazard inputs: stallF, stallD and all flush outputs are 0.
REQ-039 Reset asserted mid-FLUSH or mid-DRAIN SHALL abandon the counter without producing further flush or stall pulses after the reset edge.

Verification
REQ-040 Scenario: memReadE=1, rtE=5, rsD=5 in RUN -> for exactly 1 cycle stallF=stallD=flushE=1; then state=STALL, then RUN; rtE=0 under the same stimulus -> no stall.
REQ-041 Scenario: branchE=1, zeroE=1 in RUN -> flushD=flushE=1 that cycle; flushM=1 for exactly 3 following cycles; state back to RUN on the 4th.
REQ-042 Scenario: redirect and loaduse in the same cycle -> redirect response only (no stallF); a loaduse during FLUSH -> no stall.
REQ-043 Scenario: instrD=32'hFFFFFFFF at cycle_count=N -> DRAIN for 3 cycles; done=1 with cycle_count frozen at N+4; stallF held high from detection onward.
REQ-044 Scenario: HALT_WORD presented during FLUSH -> ignored, no DRAIN entry.
REQ-045 Scenario: reset=1 for one edge during DRAIN with counter=2 -> state=0, done=0, cycle_count=0 on the next cycle; no flushD afterwards.
